// File: rtl/led_pwm_bank.sv
// Bank of LED drivers sharing one prescaler and PWM period counter; config is double-buffered
// and applied at PWM period boundaries. Optional gamma mapping of PWM duty: define LED_GAMMA_EN.
module led_pwm_bank #(
  parameter int CHANNELS = 16,
  parameter int DUTY_W   = 8,
  parameter int PRESC_W  = 16,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PRESC_W-1:0]  prescale,
  input  logic                wr_valid,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [DUTY_W-1:0]   wr_duty,
  output logic                wr_err,
  output logic                period_tick,
  output logic [CHANNELS-1:0] led_out
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
  localparam logic [CH_W:0]     NCH      = (CH_W+1)'(CHANNELS);

`ifdef LED_GAMMA_EN
  function automatic logic [DUTY_W-1:0] gamma(input logic [DUTY_W-1:0] duty);
    logic [2*DUTY_W-1:0] prod;
    prod  = (2*DUTY_W)'(duty) * (2*DUTY_W)'(duty);
    gamma = prod[2*DUTY_W-1:DUTY_W];
  endfunction
`endif

  logic [PRESC_W-1:0]  presc_q;
  logic [DUTY_W-1:0]   pwm_q;
  mode_e               sh_mode_q   [CHANNELS];
  logic [DUTY_W-1:0]   sh_duty_q   [CHANNELS];
  mode_e               act_mode_q  [CHANNELS];
  logic [DUTY_W-1:0]   act_duty_q  [CHANNELS];
  logic [DUTY_W-1:0]   blink_cnt_q [CHANNELS];
  logic [CHANNELS-1:0] blink_ph_q;
  logic [CHANNELS-1:0] led_q;
  logic                wr_err_q;
  logic                ptick_q;

  logic                tick;
  logic                boundary;
  logic                in_range;
  logic [CHANNELS-1:0] wr_hit;
  mode_e               nxt_mode    [CHANNELS];
  logic [DUTY_W-1:0]   nxt_duty    [CHANNELS];
  logic [DUTY_W-1:0]   load_duty   [CHANNELS];
  logic [CHANNELS-1:0] led_d;

  assign tick     = (presc_q == prescale);
  assign boundary = tick && (pwm_q == DUTY_MAX);
  assign in_range = ({1'b0, wr_ch} < NCH);

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_valid && in_range && (wr_ch == CH_W'(i));
    end
  end

  // Value each channel would load at a boundary; a same-cycle write bypasses the shadow.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      nxt_mode[i] = wr_hit[i] ? mode_e'(wr_mode) : sh_mode_q[i];
      nxt_duty[i] = wr_hit[i] ? wr_duty : sh_duty_q[i];
`ifdef LED_GAMMA_EN
      load_duty[i] = (nxt_mode[i] == MODE_PWM) ? gamma(nxt_duty[i]) : nxt_duty[i];
`else
      load_duty[i] = nxt_duty[i];
`endif
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (act_mode_q[i])
        MODE_ON:    led_d[i] = 1'b1;
        MODE_PWM:   led_d[i] = (pwm_q < act_duty_q[i]);
        MODE_BLINK: led_d[i] = blink_ph_q[i];
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      pwm_q      <= '0;
      blink_ph_q <= '0;
      led_q      <= '0;
      wr_err_q   <= 1'b0;
      ptick_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        sh_mode_q[i]   <= MODE_OFF;
        sh_duty_q[i]   <= '0;
        act_mode_q[i]  <= MODE_OFF;
        act_duty_q[i]  <= '0;
        blink_cnt_q[i] <= '0;
      end
    end else begin
      presc_q  <= tick ? '0 : presc_q + 1'b1;
      if (tick) pwm_q <= pwm_q + 1'b1;
      ptick_q  <= boundary;
      wr_err_q <= wr_valid && !in_range;
      led_q    <= led_d;
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_hit[i]) begin
          sh_mode_q[i] <= mode_e'(wr_mode);
          sh_duty_q[i] <= wr_duty;
        end
        if (boundary) begin
          act_mode_q[i] <= nxt_mode[i];
          act_duty_q[i] <= load_duty[i];
          // Entering BLINK restarts the blink phase from low.
          if (nxt_mode[i] == MODE_BLINK && act_mode_q[i] != MODE_BLINK) begin
            blink_cnt_q[i] <= '0;
            blink_ph_q[i]  <= 1'b0;
          end else if (blink_cnt_q[i] == act_duty_q[i]) begin
            blink_cnt_q[i] <= '0;
            blink_ph_q[i]  <= ~blink_ph_q[i];
          end else begin
            blink_cnt_q[i] <= blink_cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  assign led_out     = led_q;
  assign wr_err      = wr_err_q;
  assign period_tick = ptick_q;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Bench for led_pwm_bank: directed duty table, multi-period sequences and a randomized run
// checked every cycle against a tick/period-count reference model.
module tb_led_pwm_bank;
  localparam int CH = 6;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam int CW = 3;
  localparam int PERIOD = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] prescale = '0;
  logic          wr_valid = 1'b0;
  logic [CW-1:0] wr_ch = '0;
  logic [1:0]    wr_mode = '0;
  logic [DW-1:0] wr_duty = '0;
  logic          wr_err;
  logic          period_tick;
  logic [CH-1:0] led_out;

  always #5 clk = ~clk;

  led_pwm_bank #(.CHANNELS(CH), .DUTY_W(DW), .PRESC_W(PW)) dut (
    .clk(clk), .reset(reset), .prescale(prescale), .wr_valid(wr_valid), .wr_ch(wr_ch),
    .wr_mode(wr_mode), .wr_duty(wr_duty), .wr_err(wr_err), .period_tick(period_tick),
    .led_out(led_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: total ticks since reset give PWM position and period index directly.
  int m_presc, m_ticks;
  int sh_mode[CH], sh_duty[CH], ac_mode[CH], ac_raw[CH], ac_eff[CH], bl_start[CH];

  logic [CH-1:0] obs_led;
  logic          obs_pt, obs_err;

  function automatic int eff_of(input int mode, input int d);
`ifdef LED_GAMMA_EN
    return (mode == 2) ? (d * d) / 256 : d;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_presc = 0;
    m_ticks = 0;
    for (int i = 0; i < CH; i++) begin
      sh_mode[i] = 0; sh_duty[i] = 0; ac_mode[i] = 0; ac_raw[i] = 0; ac_eff[i] = 0; bl_start[i] = 0;
    end
  endtask

  // One clock: drive inputs, predict outputs after the edge, sample #1 after the edge, compare.
  task automatic step(input logic rst, input logic v, input int ch, input int md, input int dt);
    logic [CH-1:0] e_led;
    logic e_pt, e_err;
    int pos, per;
    reset = rst; wr_valid = v; wr_ch = CW'(ch); wr_mode = 2'(md); wr_duty = DW'(dt);
    e_led = '0; e_pt = 1'b0; e_err = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      pos = m_ticks % PERIOD;
      per = m_ticks / PERIOD;
      for (int i = 0; i < CH; i++) begin
        case (ac_mode[i])
          1: e_led[i] = 1'b1;
          2: e_led[i] = (pos < ac_eff[i]);
          3: e_led[i] = (((per - bl_start[i]) / (ac_raw[i] + 1)) % 2) == 1;
          default: e_led[i] = 1'b0;
        endcase
      end
      e_pt  = (m_presc == int'(prescale)) && (pos == PERIOD - 1);
      e_err = v && (ch >= CH);
      if (v && ch < CH) begin
        sh_mode[ch] = md;
        sh_duty[ch] = dt;
      end
      if (e_pt) begin
        for (int i = 0; i < CH; i++) begin
          if (sh_mode[i] == 3 && ac_mode[i] != 3) bl_start[i] = per + 1;
          ac_mode[i] = sh_mode[i];
          ac_raw[i]  = sh_duty[i];
          ac_eff[i]  = eff_of(sh_mode[i], sh_duty[i]);
        end
      end
      if (m_presc == int'(prescale)) begin
        m_presc = 0;
        m_ticks++;
      end else begin
        m_presc = (m_presc + 1) % (1 << PW);
      end
    end
    @(posedge clk);
    #1;
    obs_led = led_out; obs_pt = period_tick; obs_err = wr_err;
    check("led_out", led_out, e_led);
    check("period_tick", period_tick, e_pt);
    check("wr_err", wr_err, e_err);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic wait_pt(input string name);
    int n;
    n = 0;
    idle();
    while (!obs_pt && n < 4 * PERIOD * 4) begin
      idle();
      n++;
    end
    check(name, obs_pt, 1);
  endtask

  task automatic count_high(input int ch, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      idle();
      cnt += obs_led[ch];
    end
  endtask

  typedef struct {
    int mode;
    int duty;
    int exp_high;
  } pwm_vec_t;

  pwm_vec_t vecs[7];

  initial begin
    int cnt, n;
    int bfix[CH];
    int exp_mid_a, exp_mid_b, exp_byp;
`ifdef LED_GAMMA_EN
    vecs[0] = '{0, 0, 0};   vecs[1] = '{1, 0, 256};  vecs[2] = '{2, 0, 0};
    vecs[3] = '{2, 64, 16}; vecs[4] = '{2, 255, 254}; vecs[5] = '{2, 16, 1};
    vecs[6] = '{2, 128, 64};
    exp_mid_a = 4; exp_mid_b = 64; exp_byp = 156;
`else
    vecs[0] = '{0, 0, 0};   vecs[1] = '{1, 0, 256};  vecs[2] = '{2, 0, 0};
    vecs[3] = '{2, 64, 64}; vecs[4] = '{2, 255, 255}; vecs[5] = '{2, 16, 16};
    vecs[6] = '{2, 128, 128};
    exp_mid_a = 32; exp_mid_b = 128; exp_byp = 200;
`endif
    bfix = '{0, 1, 2, 0, 1, 3};

    // Reset state
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0);
    check("reset_led", obs_led, 0);
    check("reset_pt", obs_pt, 0);
    check("reset_err", obs_err, 0);

    // Period length with prescale=0
    wait_pt("first_boundary");
    n = 0;
    idle();
    while (!obs_pt && n < 600) begin
      idle();
      n++;
    end
    check("period_len", n + 1, PERIOD);

    // Duty table on channel 3
    foreach (vecs[k]) begin
      step(1'b0, 1'b1, 3, vecs[k].mode, vecs[k].duty);
      wait_pt("table_boundary");
      count_high(3, PERIOD, cnt);
      check($sformatf("table_%0d_high", k), cnt, vecs[k].exp_high);
    end

    // Mid-period write takes effect next period; write on the boundary cycle applies at once
    step(1'b0, 1'b1, 1, 2, 32);
    wait_pt("mid_boundary");
    count_high(1, 100, cnt);
    step(1'b0, 1'b1, 1, 2, 128);
    cnt += obs_led[1];
    for (int k = 0; k < PERIOD - 101; k++) begin
      idle();
      cnt += obs_led[1];
    end
    check("mid_old_period", cnt, exp_mid_a);
    count_high(1, PERIOD, cnt);
    check("mid_new_period", cnt, exp_mid_b);
    count_high(1, PERIOD - 1, cnt);
    step(1'b0, 1'b1, 1, 2, 200);
    check("bypass_pt", obs_pt, 1);
    count_high(1, PERIOD, cnt);
    check("bypass_period", cnt, exp_byp);

    // BLINK duty=1: 512 cycles low then 512 high
    step(1'b0, 1'b1, 2, 3, 1);
    wait_pt("blink_boundary");
    count_high(2, 2 * PERIOD, cnt);
    check("blink_low_half", cnt, 0);
    count_high(2, 2 * PERIOD, cnt);
    check("blink_high_half", cnt, 2 * PERIOD);

    // Out-of-range write
    step(1'b0, 1'b1, CH, 1, 0);
    check("wr_err_pulse", obs_err, 1);
    idle();
    check("wr_err_clear", obs_err, 0);
    wait_pt("err_boundary");
    idle();
    check("err_no_change", obs_led[5:4], 0);

    // Reset mid-period with ch0 ON
    step(1'b0, 1'b1, 0, 1, 0);
    wait_pt("on_boundary");
    count_high(0, 100, cnt);
    check("on_high", cnt, 100);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      check("midreset_led", obs_led, 0);
      check("midreset_pt", obs_pt, 0);
    end
    for (int k = 0; k < 300; k++) idle();

    // Lowering prescale below the running count wraps the prescaler
    prescale = 8'd30;
    for (int k = 0; k < 20; k++) idle();
    prescale = 8'd5;
    for (int k = 0; k < 2000; k++) idle();

    // Randomized run against the model
    prescale = '0;
    step(1'b1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 20000; k++) begin
      if ($urandom_range(0, 1999) == 0) prescale = PW'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) begin
        int c, md, dt;
        c  = $urandom_range(0, 7);
        md = $urandom_range(0, 3);
        dt = (md == 3) ? bfix[c % CH] : $urandom_range(0, 255);
        step(1'b0, 1'b1, c, md, dt);
      end else begin
        idle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
